// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame assembler: default widths, payload
// capacity and the parser state encoding.
package uart_pkg;

  localparam int UART_BYTE_SIZE      = 8;
  localparam int UART_FULL_DATA_SIZE = 40;

  // Frame word holds opt + len + payload bytes, so payload capacity is two bytes short.
  function automatic int frame_maxlen(input int full_w, input int byte_w);
    return (full_w / byte_w) - 2;
  endfunction

  localparam int UART_MAXLEN = frame_maxlen(UART_FULL_DATA_SIZE, UART_BYTE_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2
  } uart_state_e;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte silence counter: counts enabled cycles and flags expiry on the
// CYCLES-th consecutive one; a clear restarts the count.
module uart_timeout_cnt #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = expired ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_asm.sv
// Assembles opt/len/payload byte streams into one frame word for uart_tx.
// Optional inter-byte timeout is enabled with macro UART_FRAME_TIMEOUT_EN.
module uart_frame_asm
  import uart_pkg::*;
#(
  parameter int FULL_DATA_SIZE = UART_FULL_DATA_SIZE,
  parameter int BYTE_SIZE      = UART_BYTE_SIZE,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [BYTE_SIZE-1:0]      in_byte,
  input  logic                      in_valid,
  output logic [FULL_DATA_SIZE-1:0] full_data,
  output logic                      out_valid,
  output logic                      err
);

  localparam int MAXLEN = frame_maxlen(FULL_DATA_SIZE, BYTE_SIZE);
  localparam int PAY_W  = FULL_DATA_SIZE - 2 * BYTE_SIZE;
  localparam int CNT_W  = (MAXLEN < 2) ? 1 : $clog2(MAXLEN + 1);
  localparam logic [BYTE_SIZE-1:0] MAXLEN_B = BYTE_SIZE'(MAXLEN);

  uart_state_e               state_q, state_d;
  logic [BYTE_SIZE-1:0]      opt_q, opt_d;
  logic [BYTE_SIZE-1:0]      len_q, len_d;
  logic [PAY_W-1:0]          payload_q, payload_d, payload_shifted;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [FULL_DATA_SIZE-1:0] full_data_q, full_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      err_q, err_d;
  logic                      timeout_expired;

  // Newest byte always lands in the low byte; older bytes move up.
  generate
    if (PAY_W > BYTE_SIZE) begin : g_shift
      assign payload_shifted = {payload_q[PAY_W-BYTE_SIZE-1:0], in_byte};
    end else begin : g_single
      assign payload_shifted = in_byte;
    end
  endgenerate

`ifdef UART_FRAME_TIMEOUT_EN
  logic mid_frame;
  assign mid_frame = (state_q != ST_IDLE);

  uart_timeout_cnt #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (CLK),
    .rst_n   (RST),
    .enable  (mid_frame && !in_valid),
    .clear   (!mid_frame || in_valid),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    opt_d       = opt_q;
    len_d       = len_q;
    payload_d   = payload_q;
    count_d     = count_q;
    full_data_d = full_data_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          opt_d   = in_byte;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (in_valid) begin
          len_d     = in_byte;
          payload_d = '0;
          if (in_byte == '0) begin
            full_data_d = {opt_q, in_byte, {PAY_W{1'b0}}};
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (in_byte > MAXLEN_B) begin
            // Oversized frame: dropped without touching the last good frame word.
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            count_d = in_byte[CNT_W-1:0];
            state_d = ST_PAYLOAD;
          end
        end else if (timeout_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_PAYLOAD: begin
        if (in_valid) begin
          payload_d = payload_shifted;
          count_d   = count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            full_data_d = {opt_q, len_q, payload_shifted};
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (timeout_expired) begin
          err_d   = 1'b1;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      opt_q       <= '0;
      len_q       <= '0;
      payload_q   <= '0;
      count_q     <= '0;
      full_data_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opt_q       <= opt_d;
      len_q       <= len_d;
      payload_q   <= payload_d;
      count_q     <= count_d;
      full_data_q <= full_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign full_data = full_data_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: doc/uart_frame_asm.md
UART_FRAME_ASM -- requirements
Module: uart_frame_asm

Interface
- REQ-001 SHALL have parameter FULL_DATA_SIZE, default 40: width of the assembled frame word.
- REQ-002 SHALL have parameter BYTE_SIZE, default 8: width of one received byte.
- REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: inter-byte timeout, used only with UART_FRAME_TIMEOUT_EN.
- REQ-004 SHALL have port CLK, input, 1: single clock; all logic on its rising edge.
- REQ-005 SHALL have port RST, input, 1: reset, asynchronous assert, active-low.
- REQ-006 SHALL have port in_byte, input, BYTE_SIZE: received byte from uart_rx.
- REQ-007 SHALL have port in_valid, input, 1: one-cycle strobe, in_byte valid.
- REQ-008 SHALL have port full_data, output, FULL_DATA_SIZE: assembled frame in uart_tx format.
- REQ-009 SHALL have port out_valid, output, 1: one-cycle pulse, full_data holds a new frame.
- REQ-010 SHALL have port err, output, 1: one-cycle pulse, frame aborted.

Function
- REQ-011 SHALL parse the byte stream as: opt byte, len byte, then len payload bytes; MAXLEN = FULL_DATA_SIZE/BYTE_SIZE - 2 (3 at defaults).
- REQ-012 SHALL implement FSM states IDLE, LEN, PAYLOAD; a byte is accepted only on a cycle with in_valid=1; there is no backpressure.
- REQ-013 SHALL transition as follows: IDLE + byte -> store opt, go to LEN.
- REQ-014 SHALL transition as follows: LEN + byte with len=0 -> frame complete, go to IDLE.
- REQ-015 SHALL transition as follows: LEN + byte with 1<=len<=MAXLEN -> go to PAYLOAD and load the remaining count.
- REQ-016 SHALL transition as follows: LEN + byte with len>MAXLEN -> err pulse, frame discarded, go to IDLE.
- REQ-017 SHALL, in PAYLOAD, shift each byte into the payload field, decrement the count, and on count reaching 0 complete the frame and go to IDLE.
- REQ-018 SHALL pack full_data as [FULL-1 -: BYTE]=opt and the next byte=len; the payload occupies the low bytes with the last received byte in [BYTE_SIZE-1:0]; unused payload bytes are 0 (e.g. opt 00, len 02, aa, bb -> 40'h00_02_00_aa_bb).
- REQ-019 SHALL assert out_valid exactly one cycle after the accepting edge of the frame's final byte; full_data SHALL update on that same edge and hold until the next completed frame.
- REQ-020 SHALL accept a byte arriving in the cycle out_valid or err is high as the opt of the next frame; back-to-back frames need no idle gap.
- REQ-021 SHALL NOT alter full_data on an aborted frame.

Reset
- REQ-022 SHALL, while RST=0, asynchronously force: state=IDLE, full_data=0, out_valid=0, err=0, count=0, and the timeout counter=0.
- REQ-023 SHALL, on reset asserted mid-frame, discard the partial frame without an err pulse; the first byte after RST deasserts is treated as opt.

Configuration
- REQ-024 SHALL support macro UART_FRAME_TIMEOUT_EN.
- REQ-025 SHALL, when UART_FRAME_TIMEOUT_EN is defined, count cycles without in_valid while in LEN or PAYLOAD, clear the count on every accepted byte, and at TIMEOUT_CYCLES pulse err for one cycle and return to IDLE.
- REQ-026 SHALL, when UART_FRAME_TIMEOUT_EN is not defined, contain no counter logic, wait for the next byte indefinitely, and pulse err only for len>MAXLEN.

Structure
- REQ-027 SHALL place BYTE_SIZE, FULL_DATA_SIZE defaults, MAXLEN and the FSM state typedef in shared package uart_pkg.
- REQ-028 SHALL implement the timeout as sub-module uart_timeout_cnt (inputs: enable, clear; output: expired), instantiated only under UART_FRAME_TIMEOUT_EN.

Verification
- REQ-029 SHALL cover: bytes 00,03,aa,bb,47 -> single out_valid with full_data=40'h00_03_aa_bb_47, one cycle after the byte 47.
- REQ-030 SHALL cover: bytes 00,02,aa,bb immediately followed by 00,01,aa -> out_valid twice, with 40'h00_02_00_aa_bb then 40'h00_01_00_00_aa.
- REQ-031 SHALL cover: bytes 05,00 -> out_valid with 40'h05_00_00_00_00; then bytes 00,04 -> err pulse, no out_valid, full_data unchanged.
- REQ-032 SHALL cover: RST=0 after bytes 00,03,aa, then bytes 00,01,47 -> no err, one out_valid with 40'h00_01_00_00_47.
- REQ-033 SHALL cover: with UART_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=16, bytes 00,03,aa then silence -> err after 16 idle cycles; next bytes 00,00 -> out_valid with 40'h00_00_00_00_00.
- REQ-034 SHALL cover: the same stimulus without the macro -> no err; the frame completes later on bytes bb,47 (40'h00_03_aa_bb_47).
